// File: rtl/seg7_scan_driver.sv
// Multiplexed common-anode 7-segment scan driver. A divided clock from the upstream
// divider is synchronised and edge-detected to step digits, with an anode-off guard.
module seg7_scan_driver #(
    parameter int unsigned N_DIGITS     = 8,
    parameter int unsigned BLANK_CYCLES = 4,
    parameter int unsigned LZ_BLANK_EN  = 1
) (
    input  logic                    clk_in,
    input  logic                    reset,
    input  logic                    tick_in,
    input  logic [4*N_DIGITS-1:0]   value,
    input  logic [N_DIGITS-1:0]     dp_en,
    input  logic                    blank_lz,
    output logic [6:0]              seg_out,
    output logic                    dp_out,
    output logic [N_DIGITS-1:0]     an_out
);

    localparam int unsigned IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
    localparam int unsigned CNT_W = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;

    typedef enum logic {SHOW, GUARD} state_e;

    state_e                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [4*N_DIGITS-1:0]   snap_val_q, snap_val_d;
    logic [N_DIGITS-1:0]     snap_dp_q, snap_dp_d;
    logic                    snap_lz_q, snap_lz_d;
    logic                    sync1_q, sync2_q, sync3_q;
    logic [6:0]              seg_q, seg_d;
    logic                    dp_q, dp_d;
    logic [N_DIGITS-1:0]     an_q, an_d;
    logic                    adv;
    logic [3:0]              nib;
    logic                    dp_bit;
    logic                    zero_run;
    logic                    lz_blank;

    assign adv = sync2_q & ~sync3_q;

    function automatic logic [6:0] hex2seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    // Next-state and registered-output computation; outputs follow the next-state values
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        cnt_d      = cnt_q;
        snap_val_d = snap_val_q;
        snap_dp_d  = snap_dp_q;
        snap_lz_d  = snap_lz_q;
        nib        = 4'h0;
        dp_bit     = 1'b0;
        zero_run   = 1'b1;
        lz_blank   = 1'b0;
        seg_d      = 7'h7F;
        dp_d       = 1'b1;
        an_d       = '1;

        case (state_q)
            SHOW: begin
                if (adv) begin
                    if (idx_q == IDX_W'(N_DIGITS - 1)) begin
                        idx_d      = '0;
                        snap_val_d = value;
                        snap_dp_d  = dp_en;
                        snap_lz_d  = (LZ_BLANK_EN != 0) ? blank_lz : 1'b0;
                    end else begin
                        idx_d = idx_q + IDX_W'(1);
                    end
                    if (BLANK_CYCLES > 0) begin
                        state_d = GUARD;
                        cnt_d   = CNT_W'(BLANK_CYCLES);
                    end
                end
            end
            GUARD: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    state_d = SHOW;
                end
            end
            default: state_d = SHOW;
        endcase

        // Walk from the most significant digit down so zero_run covers digits N-1..i
        for (int i = int'(N_DIGITS) - 1; i >= 0; i--) begin
            zero_run = zero_run & (snap_val_d[4*i +: 4] == 4'h0);
            if (idx_d == IDX_W'(i)) begin
                nib    = snap_val_d[4*i +: 4];
                dp_bit = snap_dp_d[i];
                if (i != 0 && zero_run && snap_lz_d) begin
                    lz_blank = 1'b1;
                end
            end
        end

        if (state_d == SHOW) begin
            seg_d = lz_blank ? 7'h7F : hex2seg(nib);
            dp_d  = ~dp_bit;
            an_d  = ~(N_DIGITS'(1) << idx_d);
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            sync3_q    <= 1'b0;
            state_q    <= SHOW;
            idx_q      <= '0;
            cnt_q      <= '0;
            snap_val_q <= '0;
            snap_dp_q  <= '0;
            snap_lz_q  <= 1'b0;
            seg_q      <= 7'h7F;
            dp_q       <= 1'b1;
            an_q       <= '1;
        end else begin
            sync1_q    <= tick_in;
            sync2_q    <= sync1_q;
            sync3_q    <= sync2_q;
            state_q    <= state_d;
            idx_q      <= idx_d;
            cnt_q      <= cnt_d;
            snap_val_q <= snap_val_d;
            snap_dp_q  <= snap_dp_d;
            snap_lz_q  <= snap_lz_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
        end
    end

    assign seg_out = seg_q;
    assign dp_out  = dp_q;
    assign an_out  = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver at default parameters (8 digits, 4-cycle guard).
module tb_seg7_scan_driver;

    logic        clk_in = 1'b0;
    logic        reset;
    logic        tick_in;
    logic [31:0] value;
    logic [7:0]  dp_en;
    logic        blank_lz;
    logic [6:0]  seg_out;
    logic        dp_out;
    logic [7:0]  an_out;

    int checks = 0;
    int errors = 0;
    int cur_idx = 0;

    logic [7:0] s_an  [20];
    logic [6:0] s_seg [20];
    logic       s_dp  [20];
    logic [6:0] tab_abcd [8];

    seg7_scan_driver #(.N_DIGITS(8), .BLANK_CYCLES(4), .LZ_BLANK_EN(1)) dut (
        .clk_in  (clk_in),
        .reset   (reset),
        .tick_in (tick_in),
        .value   (value),
        .dp_en   (dp_en),
        .blank_lz(blank_lz),
        .seg_out (seg_out),
        .dp_out  (dp_out),
        .an_out  (an_out)
    );

    always #5 clk_in = ~clk_in;

    // One tick_in pulse followed by a 20-cycle capture window; sample k is taken 1ns after edge k
    task automatic do_tick();
        tick_in = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk_in); #1;
            s_an[k]  = an_out;
            s_seg[k] = seg_out;
            s_dp[k]  = dp_out;
            if (k == 4) tick_in = 1'b0;
        end
        cur_idx = (cur_idx + 1) % 8;
    endtask

    task automatic wrap_frame();
        do do_tick(); while (cur_idx != 0);
    endtask

    task automatic test_reset();
        reset = 1'b1; tick_in = 1'b0; value = 32'h0; dp_en = 8'h0; blank_lz = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (an_out !== 8'hFF || seg_out !== 7'h7F || dp_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: an=%h seg=%h dp=%b required an=ff seg=7f dp=1", an_out, seg_out, dp_out);
        end
        reset = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (an_out !== 8'hFE || seg_out !== 7'h40 || dp_out !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: an=%h seg=%h dp=%b required an=fe seg=40 dp=1", an_out, seg_out, dp_out);
        end
        cur_idx = 0;
    endtask

    task automatic test_scan();
        logic [7:0] prev_an;
        logic       guard_ok;
        value = 32'h1234_ABCD; dp_en = 8'h00; blank_lz = 1'b0;
        tab_abcd = '{7'h21, 7'h46, 7'h03, 7'h08, 7'h19, 7'h30, 7'h24, 7'h79};
        wrap_frame();
        checks++;
        if (s_an[6] !== 8'hFE || s_seg[6] !== 7'h21) begin
            errors++;
            $display("FAIL scan_first_wrap: an=%h seg=%h required an=fe seg=21", s_an[6], s_seg[6]);
        end
        for (int d = 0; d < 8; d++) begin
            prev_an = ~(8'h01 << cur_idx);
            do_tick();
            checks++;
            if (s_an[1] !== prev_an) begin
                errors++;
                $display("FAIL adv_lag step %0d: an=%h required %h", d, s_an[1], prev_an);
            end
            guard_ok = (s_an[2] == 8'hFF) && (s_an[3] == 8'hFF) && (s_an[4] == 8'hFF)
                       && (s_an[5] == 8'hFF) && (s_an[6] != 8'hFF);
            checks++;
            if (!guard_ok) begin
                errors++;
                $display("FAIL guard_len step %0d: an[2..6]=%h %h %h %h %h required ff ff ff ff non-ff",
                         d, s_an[2], s_an[3], s_an[4], s_an[5], s_an[6]);
            end
            checks++;
            if (s_an[6] !== ~(8'h01 << cur_idx) || s_seg[6] !== tab_abcd[cur_idx]) begin
                errors++;
                $display("FAIL scan_digit %0d: an=%h seg=%h required an=%h seg=%h", cur_idx,
                         s_an[6], s_seg[6], ~(8'h01 << cur_idx), tab_abcd[cur_idx]);
            end
        end
    endtask

    task automatic test_lz();
        logic [6:0] exp_seg;
        blank_lz = 1'b1; value = 32'h0000_0050;
        wrap_frame();
        for (int d = 0; d < 8; d++) begin
            do_tick();
            exp_seg = (cur_idx == 0) ? 7'h40 : (cur_idx == 1) ? 7'h12 : 7'h7F;
            checks++;
            if (s_seg[6] !== exp_seg) begin
                errors++;
                $display("FAIL lz_50 digit %0d: seg=%h required %h", cur_idx, s_seg[6], exp_seg);
            end
        end
        value = 32'h0;
        wrap_frame();
        for (int d = 0; d < 8; d++) begin
            do_tick();
            exp_seg = (cur_idx == 0) ? 7'h40 : 7'h7F;
            checks++;
            if (s_seg[6] !== exp_seg) begin
                errors++;
                $display("FAIL lz_zero digit %0d: seg=%h required %h", cur_idx, s_seg[6], exp_seg);
            end
        end
    endtask

    task automatic test_dp();
        logic exp_dp;
        blank_lz = 1'b0; dp_en = 8'h04; value = 32'h1234_ABCD;
        wrap_frame();
        for (int d = 0; d < 8; d++) begin
            do_tick();
            exp_dp = (cur_idx == 2) ? 1'b0 : 1'b1;
            checks++;
            if (s_dp[6] !== exp_dp || s_dp[3] !== 1'b1) begin
                errors++;
                $display("FAIL dp digit %0d: dp=%b guard_dp=%b required dp=%b guard_dp=1",
                         cur_idx, s_dp[6], s_dp[3], exp_dp);
            end
        end
        dp_en = 8'h00;
    endtask

    task automatic test_midframe();
        value = 32'h1234_ABCD;
        wrap_frame();
        repeat (3) do_tick();
        value = 32'hFFFF_FFFF;
        for (int d = 0; d < 4; d++) begin
            do_tick();
            checks++;
            if (s_seg[6] !== tab_abcd[cur_idx]) begin
                errors++;
                $display("FAIL midframe_hold digit %0d: seg=%h required %h", cur_idx, s_seg[6], tab_abcd[cur_idx]);
            end
        end
        do_tick();
        checks++;
        if (cur_idx != 0 || s_seg[6] !== 7'h0E) begin
            errors++;
            $display("FAIL midframe_new: seg=%h required 0e", s_seg[6]);
        end
    endtask

    task automatic test_back_to_back();
        logic [7:0] exp_an;
        exp_an = ~(8'h01 << ((cur_idx + 1) % 8));
        tick_in = 1'b1;
        @(posedge clk_in); #1;
        tick_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        tick_in = 1'b1;
        @(posedge clk_in); #1;
        tick_in = 1'b0;
        repeat (3) @(posedge clk_in);
        #1;
        checks++;
        if (an_out !== exp_an) begin
            errors++;
            $display("FAIL b2b_guard_end: an=%h required %h", an_out, exp_an);
        end
        repeat (14) @(posedge clk_in);
        #1;
        checks++;
        if (an_out !== exp_an) begin
            errors++;
            $display("FAIL b2b_single_adv: an=%h required %h", an_out, exp_an);
        end
        cur_idx = (cur_idx + 1) % 8;
    endtask

    task automatic test_reset_guard();
        tick_in = 1'b1;
        repeat (3) @(posedge clk_in);
        #1;
        tick_in = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (an_out !== 8'hFF) begin
            errors++;
            $display("FAIL rg_in_guard: an=%h required ff", an_out);
        end
        reset = 1'b1;
        @(posedge clk_in); #1;
        checks++;
        if (an_out !== 8'hFF || seg_out !== 7'h7F || dp_out !== 1'b1) begin
            errors++;
            $display("FAIL rg_reset: an=%h seg=%h dp=%b required an=ff seg=7f dp=1", an_out, seg_out, dp_out);
        end
        reset = 1'b0;
        @(posedge clk_in); #1;
        checks++;
        if (an_out !== 8'hFE || seg_out !== 7'h40 || dp_out !== 1'b1) begin
            errors++;
            $display("FAIL rg_idx0: an=%h seg=%h dp=%b required an=fe seg=40 dp=1", an_out, seg_out, dp_out);
        end
        repeat (8) @(posedge clk_in);
        #1;
        checks++;
        if (an_out !== 8'hFE) begin
            errors++;
            $display("FAIL rg_stable: an=%h required fe", an_out);
        end
        cur_idx = 0;
    endtask

    initial begin
        test_reset();
        test_scan();
        test_lz();
        test_dp();
        test_midframe();
        test_back_to_back();
        test_reset_guard();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Multiplexed 7-segment display driver that consumes the square-wave output of the team's clock divider as its scan-rate source.
- Synchronises that slow signal into the clk_in domain and edge-detects it.
- Each rising edge advances to the next digit, with a short all-anodes-off guard interval to prevent ghosting.
- Sits between the clock divider and the board's common-anode segment/anode pins.

Parameters:
- N_DIGITS, 8: number of multiplexed digits; legal range 1..16.
- BLANK_CYCLES, 4: clk_in cycles during which all anodes are off after each digit advance; 0 disables the guard interval.
- LZ_BLANK_EN, 1: 1 enables leading-zero blanking whenever blank_lz is high; 0 forces blanking off regardless of blank_lz.

Ports:
- clk_in  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- tick_in  in  1  divided clock from upstream divider; treated as asynchronous data, never used as a clock.
- value  in  4*N_DIGITS  hex nibbles; nibble i = value[4i+3:4i]; digit 0 is the rightmost digit.
- dp_en  in  N_DIGITS  decimal point request per digit, active-high.
- blank_lz  in  1  requests leading-zero blanking.
- seg_out  out  7  {g,f,e,d,c,b,a}, active-low.
- dp_out  out  1  decimal point, active-low.
- an_out  out  N_DIGITS  anode enables, active-low, at most one bit low.

Behaviour:
- Widths:
  - idx width is max(1, $clog2(N_DIGITS)).
  - Guard counter width is max(1, $clog2(BLANK_CYCLES+1)).
- Reset: clk_in is the only clock; reset is synchronous and active-high. While reset is high:
  - sync1, sync2, sync3 = 0; idx = 0; guard counter = 0; state = SHOW.
  - snap_val = 0; snap_dp = 0; snap_lz = 0.
  - an_out = all 1s; seg_out = 7'h7F; dp_out = 1.
- Outputs are registered. On the first clk_in edge with reset low, the outputs show digit 0 of the snapshot, which is "0" with no decimal point.
- Synchroniser and edge detect:
  - Chain: sync1 <= tick_in, sync2 <= sync1, sync3 <= sync2.
  - adv = sync2 & ~sync3.
  - tick_in sampled high at edge E0 gives adv high between E1 and E2.
  - adv is one cycle wide per tick_in rising edge.
  - A tick_in already high at reset release produces one adv.
- States: SHOW, GUARD.
- SHOW:
  - an_out drives bit idx low; seg_out and dp_out reflect digit idx.
  - On adv, idx <= (idx == N_DIGITS-1) ? 0 : idx+1.
  - If BLANK_CYCLES > 0, the same adv also sets state <= GUARD, loads the guard counter with BLANK_CYCLES, and forces an_out, seg_out and dp_out to all 1s on that edge.
  - If BLANK_CYCLES = 0, the outputs switch directly to the new digit on that edge.
- GUARD:
  - All outputs stay inactive and the counter decrements each cycle.
  - When the counter reaches 1, state <= SHOW and the outputs show the new idx on that edge.
  - Off-time is exactly BLANK_CYCLES cycles.
  - adv arriving in GUARD is ignored: no idx change and no extension of the guard time.
- Snapshot:
  - snap_val, snap_dp and snap_lz (= blank_lz & LZ_BLANK_EN) are loaded on the adv edge that wraps idx to 0.
  - Changes to value mid-frame therefore never tear a frame.
- Decode for nibbles 0..F (seg_out hex): 40, 79, 24, 30, 19, 12, 02, 78, 00, 10, 08, 03, 46, 21, 06, 0E.
- Leading-zero blanking: digit i (i ≥ 1) is blanked (seg_out = 7'h7F) when snap_lz = 1 and snap nibbles N_DIGITS-1 down to i are all zero. Digit 0 is never blanked.
- dp_out = ~snap_dp[idx] in SHOW, independent of blanking.
- Reset mid-GUARD or mid-frame: the reset state above applies on the next edge.
- N_DIGITS = 1: idx stays 0, adv still triggers GUARD, and the snapshot reloads on every adv.

Test Plan:
- Reset with value = 32'h0000_0000, then release → next cycle an_out = 8'hFE, seg_out = 7'h40, dp_out = 1.
- value = 32'h1234_ABCD, drive one tick_in rise per 20 cycles with BLANK_CYCLES = 4:
  - After the first wrap, digits 0..7 show 0x21, 0x46, 0x03, 0x08, 0x19, 0x30, 0x24, 0x79.
  - an_out walks FE→FD→…→7F→FE.
  - Each transition is preceded by exactly 4 cycles of an_out = 8'hFF.
  - adv lags the tick_in rise by 2 cycles.
- blank_lz = 1, value = 32'h0000_0050:
  - Digits 7..2 show 7'h7F; digit 1 shows 7'h12; digit 0 shows 7'h40.
  - With value = 0, only digit 0 is lit, showing 7'h40.
- dp_en = 8'h04 → dp_out = 0 only while an_out = 8'hFB.
- Change value mid-frame at idx = 3 → the displayed digits do not change until idx wraps to 0.
- Edge cases:
  - Two tick_in rises 3 cycles apart with BLANK_CYCLES = 4 → idx advances once.
  - Assert reset during GUARD → next cycle all outputs are inactive and idx = 0.
